mux_scan_sel: RTL and testbench

//  Parametrised N-channel, W-bit registered channel selector with auto-scan.

---
 rtl/mux_scan_sel.sv | 108 ++++++++++
 tb/tb_mux_scan_sel.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sel.sv
// Registered N-channel selector: manual select or timed auto-scan.
// Scanning can pause and resume with its dwell count intact.
module mux_scan_sel #(
  parameter  int WIDTH    = 2,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 50_000_000,
  localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLOCK_50,
  input  logic                      RESETN,
  input  logic [CHANNELS*WIDTH-1:0] DIN,
  input  logic [SELW-1:0]           SEL,
  input  logic                      MODE,
  input  logic                      HOLD,
  output logic [WIDTH-1:0]          DOUT,
  output logic [SELW-1:0]           CH,
  output logic                      CH_STB
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SELW:0]   NCH   = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST  = SELW'(CHANNELS - 1);
  localparam logic [CNTW-1:0] CLAST = CNTW'(DWELL - 1);

  typedef enum logic [1:0] {
    MANUAL,
    SCAN,
    PAUSED
  } state_t;

  state_t          state, state_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [SELW-1:0] ch_n;
  logic [SELW-1:0] sel_ch;
  logic [WIDTH-1:0] data_n;

  // Out-of-range manual selects leave the current channel in place.
  assign sel_ch = ({1'b0, SEL} < NCH) ? SEL : CH;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ch_n    = CH;
    unique case (state)
      MANUAL: begin
        if (MODE) begin
          state_n = SCAN;
          cnt_n   = '0;
        end else begin
          ch_n = sel_ch;
        end
      end
      SCAN: begin
        if (!MODE) begin
          state_n = MANUAL;
          ch_n    = sel_ch;
          cnt_n   = '0;
        end else if (HOLD) begin
          state_n = PAUSED;
        end else if (cnt == CLAST) begin
          cnt_n = '0;
          ch_n  = (CH == LAST) ? '0 : CH + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PAUSED: begin
        if (!MODE) begin
          state_n = MANUAL;
          ch_n    = sel_ch;
          cnt_n   = '0;
        end else if (!HOLD) begin
          state_n = SCAN;
        end
      end
      default: begin
        state_n = MANUAL;
        cnt_n   = '0;
      end
    endcase
  end

  // Data follows the channel being loaded this edge, keeping DOUT and CH aligned.
  always_comb begin
    data_n = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_n == SELW'(k)) data_n = DIN[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESETN) begin
      state  <= MANUAL;
      cnt    <= '0;
      CH     <= '0;
      DOUT   <= '0;
      CH_STB <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      CH     <= ch_n;
      DOUT   <= data_n;
      CH_STB <= (ch_n != CH);
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed checks of mux_scan_sel: reset, manual, scan, pause,
// range/exit with three channels, DWELL=1 stepping, mid-scan reset.
module tb_mux_scan_sel;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] din;
  logic [1:0] sel;
  logic       mode;
  logic       hold;

  logic [1:0] dout4, ch4;
  logic       stb4;
  logic [1:0] dout3, ch3;
  logic       stb3;
  logic [1:0] dout1, ch1;
  logic       stb1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_scan_sel #(.WIDTH(2), .CHANNELS(4), .DWELL(4)) dut (
    .CLOCK_50(clk), .RESETN(rstn), .DIN(din), .SEL(sel),
    .MODE(mode), .HOLD(hold),
    .DOUT(dout4), .CH(ch4), .CH_STB(stb4)
  );

  mux_scan_sel #(.WIDTH(2), .CHANNELS(3), .DWELL(4)) dut3 (
    .CLOCK_50(clk), .RESETN(rstn), .DIN(din[5:0]), .SEL(sel),
    .MODE(mode), .HOLD(hold),
    .DOUT(dout3), .CH(ch3), .CH_STB(stb3)
  );

  mux_scan_sel #(.WIDTH(2), .CHANNELS(4), .DWELL(1)) dut1 (
    .CLOCK_50(clk), .RESETN(rstn), .DIN(din), .SEL(sel),
    .MODE(mode), .HOLD(hold),
    .DOUT(dout1), .CH(ch1), .CH_STB(stb1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [1:0] c,
                      input logic [1:0] d, input logic s);
    check({tag, ".ch"}, {6'd0, ch4}, {6'd0, c});
    check({tag, ".dout"}, {6'd0, dout4}, {6'd0, d});
    check({tag, ".stb"}, {7'd0, stb4}, {7'd0, s});
  endtask

  task automatic chk3(input string tag, input logic [1:0] c,
                      input logic [1:0] d, input logic s);
    check({tag, ".ch3"}, {6'd0, ch3}, {6'd0, c});
    check({tag, ".dout3"}, {6'd0, dout3}, {6'd0, d});
    check({tag, ".stb3"}, {7'd0, stb3}, {7'd0, s});
  endtask

  initial begin
    // 1: reset wins over MODE=1
    rstn = 1'b0; din = 8'hE4; sel = 2'd0; mode = 1'b1; hold = 1'b0;
    tick();
    chk4("rst", 2'd0, 2'b00, 1'b0);
    chk3("rst", 2'd0, 2'b00, 1'b0);

    // 2: manual select, then data change on same channel
    rstn = 1'b1; mode = 1'b0; sel = 2'd2;
    tick();
    chk4("man_sel", 2'd2, 2'b10, 1'b1);
    tick();
    chk4("man_hold", 2'd2, 2'b10, 1'b0);
    din = 8'hD4;
    tick();
    chk4("man_din", 2'd2, 2'b01, 1'b0);

    // 3: scan from channel 0; E4 gives channel k = k
    din = 8'hE4; sel = 2'd0;
    tick();
    chk4("man_ch0", 2'd0, 2'b00, 1'b1);
    mode = 1'b1;
    tick();
    chk4("scan_enter", 2'd0, 2'b00, 1'b0);
    for (int s = 1; s <= 4; s++) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        if (s == 1 && i < 2)
          check("dwell1_ch", {6'd0, ch1}, 8'(i + 1));
        chk4("scan_dwell", 2'(s - 1), 2'(s - 1), 1'b0);
      end
      tick();
      chk4("scan_step", 2'(s), 2'(s), 1'b1);
    end

    // 4: pause on channel 1 with two dwell clocks spent
    repeat (4) tick();
    chk4("pre_pause", 2'd1, 2'b01, 1'b1);
    repeat (2) tick();
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk4("paused", 2'd1, 2'b01, 1'b0);
    end
    hold = 1'b0;
    tick();
    chk4("resume_edge", 2'd1, 2'b01, 1'b0);
    tick();
    chk4("resume_cnt3", 2'd1, 2'b01, 1'b0);
    tick();
    chk4("resume_step", 2'd2, 2'b10, 1'b1);

    // 6: reset for one clock while CH=3, cnt=2
    repeat (4) tick();
    repeat (2) tick();
    chk4("pre_rst", 2'd3, 2'b11, 1'b0);
    rstn = 1'b0;
    tick();
    chk4("mid_rst", 2'd0, 2'b00, 1'b0);
    rstn = 1'b1;
    // MODE still 1: a fresh MANUAL->SCAN entry delays the first step
    for (int i = 0; i < 4; i++) begin
      tick();
      chk4("post_rst", 2'd0, 2'b00, 1'b0);
    end
    tick();
    chk4("post_rst_step", 2'd1, 2'b01, 1'b1);

    // 5: three-channel instance: range hold, wrap 2->0, MODE beats HOLD
    rstn = 1'b0;
    tick();
    rstn = 1'b1; mode = 1'b0; sel = 2'd2;
    tick();
    chk3("r3_sel2", 2'd2, 2'b10, 1'b1);
    sel = 2'd3;
    tick();
    chk3("r3_sel3", 2'd2, 2'b10, 1'b0);
    chk4("r4_sel3", 2'd3, 2'b11, 1'b1);
    mode = 1'b1;
    tick();
    chk3("r3_enter", 2'd2, 2'b10, 1'b0);
    repeat (3) tick();
    chk3("r3_dwell", 2'd2, 2'b10, 1'b0);
    tick();
    chk3("r3_wrap", 2'd0, 2'b00, 1'b1);
    hold = 1'b1;
    tick();
    chk3("r3_pause", 2'd0, 2'b00, 1'b0);
    mode = 1'b0; sel = 2'd1;
    tick();
    chk3("r3_exit", 2'd1, 2'b01, 1'b1);
    tick();
    chk3("r3_manual", 2'd1, 2'b01, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
